// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch unit. It keeps at most one memory read in
//               flight and holds returned words in a small FIFO for the
//               decoder. A pipeline redirect flushes the FIFO, and any read
//               that was already requested is dropped when it returns.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // pipeline redirect
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // decoder side
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] HEAD_LAST = PTR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]       r_state;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_buf_data [DEPTH];
  logic [31:0]      r_buf_pc   [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_grant;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W:0]   w_tail_sum;
  logic [PTR_W-1:0] w_tail;
  logic [PTR_W-1:0] w_head_nxt;
  logic [31:0]      w_redirect_tgt;
  logic             w_unused_low_bits;

  // The two low bits of a redirect target are meaningless for word fetches.
  assign w_redirect_tgt    = {redirect_pc[31:2], 2'b00};
  assign w_unused_low_bits = ^redirect_pc[1:0];

  assign w_full   = (r_count == DEPTH_CNT);
  assign imem_req = (r_state == S_REQ) && !w_full;
  assign imem_addr = r_fetch_pc;
  assign w_grant  = imem_req && imem_gnt;

  // A redirect on the response edge wins: the returning word is stale.
  assign w_push = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop  = inst_valid && inst_ready;

  // Circular buffer: tail sits count entries past the head.
  assign w_tail_sum = (CNT_W+1)'(r_head) + (CNT_W+1)'(r_count);
  assign w_tail     = (w_tail_sum >= DEPTH_SUM) ? PTR_W'(w_tail_sum - DEPTH_SUM)
                                                : PTR_W'(w_tail_sum);
  assign w_head_nxt = (r_head == HEAD_LAST) ? '0 : r_head + PTR_W'(1);

  assign inst_valid = (r_count != '0);
  assign inst       = inst_valid ? r_buf_data[r_head] : 32'h0;
  assign inst_pc    = inst_valid ? r_buf_pc[r_head]   : 32'h0;

  // Fetch FSM: one outstanding read; a redirect while a read is in flight
  // parks in DROP until that stale response returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (w_grant) begin
            r_state <= redirect_valid ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_state <= S_REQ;
          end else if (redirect_valid) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Fetch address: redirect target, otherwise advance after each kept word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_tgt;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // FIFO occupancy and head pointer; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_head  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= w_head_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the valid-gated outputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[w_tail] <= imem_rdata;
      r_buf_pc[w_tail]   <= r_fetch_pc;
    end
  end

endmodule
`default_nettype wire
